// File: rtl/mem_write_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_write_sequencer
//  Description : Byte FIFO feeding sequential writes into a small memory, with
//                a readback compare after each store and a sticky error flag.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_write_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          load_addr,
    input  logic [AW-1:0] start_addr,
    input  logic          clr_err,
    output logic [7:0]    mem_data,
    output logic          mem_store,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_q,
    output logic          busy,
    output logic          err,
    output logic [7:0]    wr_count
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2,
        S_CHECK  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [7:0]         r_fifo [DEPTH];
    logic [c_PTR_W-1:0] r_rd_idx;
    logic [c_PTR_W-1:0] r_wr_idx;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic [7:0]         w_head;

    logic [AW-1:0]      r_wr_ptr;
    logic [7:0]         r_chk_byte;
    logic [7:0]         r_mem_data_q;
    logic [7:0]         r_wr_count;
    logic               r_err;

    // ---------------------------------------------------------------- FIFO
    assign in_ready = (r_count != c_FULL);
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && in_ready;
    // ISSUE is only ever entered with a non-empty FIFO, so the pop is unconditional
    assign w_pop    = (r_state == S_ISSUE);
    assign w_head   = r_fifo[r_rd_idx];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_idx <= '0;
            r_wr_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_idx <= r_wr_idx + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_idx <= r_rd_idx + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        mem_store    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_store    = 1'b1;
                w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                w_state_next = S_CHECK;
            end
            S_CHECK: begin
                w_state_next = w_empty ? S_IDLE : S_ISSUE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_chk_byte   <= '0;
            r_mem_data_q <= '0;
            r_wr_count   <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_addr) begin
                        r_wr_ptr <= start_addr;
                    end
                end
                S_ISSUE: begin
                    r_chk_byte   <= w_head;
                    r_mem_data_q <= w_head;
                end
                S_CHECK: begin
                    r_wr_count <= r_wr_count + 8'd1;
                    r_wr_ptr   <= r_wr_ptr + AW'(1);
                end
                default: begin
                end
            endcase

            // a fresh mismatch outranks a simultaneous clear
            if ((r_state == S_CHECK) && (mem_q != r_chk_byte)) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign mem_data = mem_store ? w_head : r_mem_data_q;
    assign mem_addr = r_wr_ptr;
    assign busy     = (r_state != S_IDLE) || !w_empty;
    assign err      = r_err;
    assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_write_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_write_sequencer
//  Description : Randomised bench for mem_write_sequencer against a queue-based
//                reference model and a behavioural downstream memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_write_sequencer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          load_addr;
    logic [AW-1:0] start_addr;
    logic          clr_err;
    logic [7:0]    mem_data;
    logic          mem_store;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_q;
    logic          busy;
    logic          err;
    logic [7:0]    wr_count;

    always #5 clk = ~clk;

    mem_write_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .load_addr  (load_addr),
        .start_addr (start_addr),
        .clr_err    (clr_err),
        .mem_data   (mem_data),
        .mem_store  (mem_store),
        .mem_addr   (mem_addr),
        .mem_q      (mem_q),
        .busy       (busy),
        .err        (err),
        .wr_count   (wr_count)
    );

    // downstream memory; force_zero corrupts the readback path
    logic [7:0] mem [4] = '{default: 8'h00};
    logic       force_zero = 1'b0;
    always @(posedge clk) if (mem_store) mem[mem_addr] <= mem_data;
    assign mem_q = force_zero ? 8'h00 : mem[mem_addr];

    // reference model state
    logic [7:0]    exp_q [$];
    logic [7:0]    exp_mem [4] = '{default: 8'h00};
    logic [AW-1:0] exp_ptr = '0;
    logic [7:0]    exp_count = '0;
    logic          exp_err = 1'b0;
    int            accepted = 0;
    int            stored = 0;
    logic [7:0]    mon_b;
    logic          saw_not_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // per-cycle model: occupancy-derived in_ready and in-order store contents
    always @(negedge clk) begin
        check("in_ready", {31'b0, in_ready}, {31'b0, (accepted - stored) != DEPTH});
        if (exp_q.size() == 0) begin
            check("no_store", {31'b0, mem_store}, 32'd0);
        end else if (mem_store) begin
            mon_b = exp_q.pop_front();
            check("st_addr", {30'b0, mem_addr}, {30'b0, exp_ptr});
            check("st_data", {24'b0, mem_data}, {24'b0, mon_b});
            exp_mem[exp_ptr] = mon_b;
            if (force_zero && mon_b != 8'h00) exp_err = 1'b1;
            exp_ptr   = exp_ptr + 1'b1;
            exp_count = exp_count + 8'd1;
            stored++;
        end
    end

    // caller is at a negedge; reset applies at the next posedge
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        exp_q.delete();
        accepted  = 0;
        stored    = 0;
        exp_ptr   = '0;
        exp_count = '0;
        exp_err   = 1'b0;
        @(negedge clk);
        check("rst_store", {31'b0, mem_store}, 32'd0);
        check("rst_data", {24'b0, mem_data}, 32'd0);
        check("rst_addr", {30'b0, mem_addr}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_count", {24'b0, wr_count}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            saw_not_ready = 1'b1;
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("send_timeout", {31'b0, in_ready}, 32'd1);
        end else begin
            @(posedge clk);
            exp_q.push_back(b);
            accepted++;
        end
    endtask

    task automatic end_send();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_store();
        int t;
        t = 0;
        @(negedge clk);
        while (!mem_store && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!mem_store) check("store_timeout", {31'b0, mem_store}, 32'd1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("idle", {31'b0, busy}, 32'd0);
        check("wr_count", {24'b0, wr_count}, {24'b0, exp_count});
        check("err", {31'b0, err}, {31'b0, exp_err});
        check("idle_addr", {30'b0, mem_addr}, {30'b0, exp_ptr});
        for (int i = 0; i < 4; i++) begin
            check("mem", {24'b0, mem[i]}, {24'b0, exp_mem[i]});
        end
    endtask

    task automatic load(input logic [AW-1:0] a);
        @(negedge clk);
        load_addr  = 1'b1;
        start_addr = a;
        @(posedge clk);
        exp_ptr = a;
        @(negedge clk);
        load_addr = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        exp_err = 1'b0;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        load_addr  = 1'b0;
        start_addr = '0;
        clr_err    = 1'b0;
        do_reset();

        // 1: four bytes from pointer 0, with latency check on the first
        send(8'h11);
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_n", {31'b0, mem_store}, 32'd0);
        @(negedge clk);
        check("lat_n1", {31'b0, mem_store}, 32'd1);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        end_send();
        wait_idle();

        // 2: wrap from address 3
        load(2'd3);
        send(8'hA5);
        send(8'h5A);
        end_send();
        wait_idle();

        // 3: six back-to-back bytes must fill the FIFO
        saw_not_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(8'($urandom));
        end_send();
        wait_idle();
        check("full_seen", {31'b0, saw_not_ready}, 32'd1);

        // 4: readback corruption, stickiness, clear, and set-beats-clear
        force_zero = 1'b1;
        send(8'hFF);
        end_send();
        wait_idle();
        force_zero = 1'b0;
        send(8'h3C);
        send(8'hC3);
        end_send();
        wait_idle();
        pulse_clr();
        @(negedge clk);
        check("err_clr", {31'b0, err}, 32'd0);
        force_zero = 1'b1;
        send(8'hFF);
        end_send();
        wait_store();
        @(negedge clk);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        wait_idle();
        force_zero = 1'b0;
        pulse_clr();

        // 6: load_addr during ISSUE is ignored
        a = exp_ptr + 2'd2;
        send(8'h69);
        send(8'h96);
        end_send();
        wait_store();
        load_addr  = 1'b1;
        start_addr = a;
        @(negedge clk);
        load_addr = 1'b0;
        wait_idle();

        // randomized traffic with gaps, reloads and clears
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                end_send();
                wait_idle();
                load(AW'($urandom));
                if ($urandom_range(0, 1) == 1) pulse_clr();
            end else begin
                send(8'($urandom));
                if ($urandom_range(0, 2) == 0) begin
                    end_send();
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        end
        end_send();
        wait_idle();

        // 5: reset during SETTLE drops the in-flight verify and the queued byte
        send(8'h5E);
        send(8'hE5);
        end_send();
        wait_store();
        @(negedge clk);
        do_reset();
        repeat (12) @(negedge clk);
        check("post_rst_count", {24'b0, wr_count}, 32'd0);
        check("post_rst_busy", {31'b0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
